// File: rtl/rx_pkt_parser.sv
// Receive packet parser: turns the CC1200 byte stream into frame-memory writes
// (frame sync, line address, 12-bit pixels). Define RXPARSE_CRC_GATE_EN to buffer and CRC-gate data packets.
module rx_pkt_parser #(
    parameter int unsigned MAX_PIX    = 64,
    parameter logic [7:0]  FRAME_TYPE = 8'hA5,
    parameter logic [7:0]  DATA_TYPE  = 8'h5A,
    parameter logic [15:0] ADDR_LIMIT = 16'h9600
) (
    input  logic        Cclk,
    input  logic        rstn,
    input  logic [7:0]  RxByte,
    input  logic        RxByteValid,
    input  logic        RxPktStart,
    input  logic        RxPktEnd,
    input  logic        RxCrcOk,
    output logic        FraimSync,
    output logic        LineSync,
    output logic [15:0] RxAdd,
    output logic        RxAddValid,
    output logic [11:0] RxData,
    output logic        RxValid,
    output logic [7:0]  ErrCnt
);

    localparam int unsigned CNT_W = 7;
    localparam int unsigned PIX_W = 12;

    typedef enum logic [3:0] {
        S_IDLE, S_FRM, S_ADDH, S_ADDL, S_CNT,
        S_PB0, S_PB1, S_PB2, S_DONE, S_SKIP, S_DRAIN
    } state_t;

    state_t             state, state_d;
    logic [15:0]        addr, addr_d;
    logic [CNT_W-1:0]   npix, npix_d, cnt, cnt_d, cnt_inc;
    logic [7:0]         hold, hold_d;
    logic [3:0]         nib, nib_d;
    logic               fs_d, ls_d, av_d, rv_d;
    logic [15:0]        add_d;
    logic [PIX_W-1:0]   data_d, pix_val;
    logic               abort_err, pkt_err, frm_end, line_end, pix_emit;
    logic [8:0]         err_sum;
    logic [7:0]         err_d;

`ifdef RXPARSE_CRC_GATE_EN
    localparam int unsigned IDX_W = $clog2(MAX_PIX);
    logic [PIX_W-1:0] pix_buf [MAX_PIX];

    // Pixel holding buffer; released only after a good CRC.
    always_ff @(posedge Cclk) begin
        if (pix_emit) pix_buf[IDX_W'(cnt)] <= pix_val;
    end
`else
    logic crc_unused;
    assign crc_unused = RxCrcOk;
`endif

    always_comb begin
        state_d   = state;
        addr_d    = addr;
        npix_d    = npix;
        cnt_d     = cnt;
        hold_d    = hold;
        nib_d     = nib;
        fs_d      = 1'b0;
        ls_d      = 1'b0;
        av_d      = 1'b0;
        rv_d      = 1'b0;
        add_d     = RxAdd;
        data_d    = RxData;
        abort_err = 1'b0;
        pkt_err   = 1'b0;
        frm_end   = 1'b0;
        line_end  = 1'b0;
        pix_emit  = 1'b0;
        pix_val   = '0;
        cnt_inc   = cnt + CNT_W'(1);

        if (state == S_DRAIN) begin
`ifdef RXPARSE_CRC_GATE_EN
            if (cnt == npix) begin
                ls_d    = 1'b1;
                state_d = S_IDLE;
            end else begin
                rv_d   = 1'b1;
                data_d = pix_buf[IDX_W'(cnt)];
                cnt_d  = cnt_inc;
            end
`else
            state_d = S_IDLE;
`endif
        end else if (RxByteValid) begin
            if (RxPktStart) begin
                // A start byte always begins a new packet, aborting any in flight.
                abort_err = (state != S_IDLE);
                cnt_d     = '0;
                if (RxByte == FRAME_TYPE) begin
                    frm_end = RxPktEnd;
                    state_d = RxPktEnd ? S_IDLE : S_FRM;
                end else if (RxByte == DATA_TYPE) begin
                    pkt_err = RxPktEnd;
                    state_d = RxPktEnd ? S_IDLE : S_ADDH;
                end else begin
                    state_d = RxPktEnd ? S_IDLE : S_SKIP;
                end
            end else begin
                case (state)
                    S_FRM:  frm_end = RxPktEnd;
                    S_ADDH: begin addr_d[15:8] = RxByte; state_d = S_ADDL; end
                    S_ADDL: begin addr_d[7:0]  = RxByte; state_d = S_CNT;  end
                    S_CNT: begin
                        npix_d = CNT_W'(RxByte);
                        if (RxByte == '0 || RxByte > 8'(MAX_PIX) || addr >= ADDR_LIMIT) begin
                            pkt_err = 1'b1;
                            state_d = S_SKIP;
                        end else begin
`ifndef RXPARSE_CRC_GATE_EN
                            av_d  = 1'b1;
                            add_d = addr;
`endif
                            state_d = S_PB0;
                        end
                    end
                    S_PB0: begin hold_d = RxByte; state_d = S_PB1; end
                    S_PB1: begin
                        pix_emit = 1'b1;
                        pix_val  = {hold, RxByte[7:4]};
                        nib_d    = RxByte[3:0];
                        cnt_d    = cnt_inc;
                        state_d  = (cnt_inc == npix) ? S_DONE : S_PB2;
                    end
                    S_PB2: begin
                        pix_emit = 1'b1;
                        pix_val  = {nib, RxByte};
                        cnt_d    = cnt_inc;
                        state_d  = (cnt_inc == npix) ? S_DONE : S_PB0;
                    end
                    default: ;
                endcase

                // End of packet: clean only if every pixel has been produced.
                if (RxPktEnd && state != S_IDLE) begin
                    if (state_d == S_DONE) line_end = 1'b1;
                    else if (state_d != S_SKIP && state != S_FRM) pkt_err = 1'b1;
                    state_d = S_IDLE;
                end
            end
        end

`ifdef RXPARSE_CRC_GATE_EN
        if (frm_end) begin
            if (RxCrcOk) fs_d = 1'b1;
            else         pkt_err = 1'b1;
        end
        if (line_end) begin
            if (RxCrcOk) begin
                state_d = S_DRAIN;
                av_d    = 1'b1;
                add_d   = addr;
                cnt_d   = '0;
            end else begin
                pkt_err = 1'b1;
            end
        end
`else
        fs_d = frm_end;
        ls_d = line_end;
        rv_d = pix_emit;
        if (pix_emit) data_d = pix_val;
`endif

        err_sum = {1'b0, ErrCnt} + 9'(abort_err) + 9'(pkt_err);
        err_d   = err_sum[8] ? 8'hFF : err_sum[7:0];
    end

    always_ff @(posedge Cclk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_IDLE;
            addr       <= '0;
            npix       <= '0;
            cnt        <= '0;
            hold       <= '0;
            nib        <= '0;
            FraimSync  <= 1'b0;
            LineSync   <= 1'b0;
            RxAdd      <= '0;
            RxAddValid <= 1'b0;
            RxData     <= '0;
            RxValid    <= 1'b0;
            ErrCnt     <= '0;
        end else begin
            state      <= state_d;
            addr       <= addr_d;
            npix       <= npix_d;
            cnt        <= cnt_d;
            hold       <= hold_d;
            nib        <= nib_d;
            FraimSync  <= fs_d;
            LineSync   <= ls_d;
            RxAdd      <= add_d;
            RxAddValid <= av_d;
            RxData     <= data_d;
            RxValid    <= rv_d;
            ErrCnt     <= err_d;
        end
    end

endmodule

// File: tb/tb_rx_pkt_parser.sv
// Scoreboard bench for rx_pkt_parser (streaming build): a packet-level model
// queues expected output events; a monitor pops them as the DUT pulses.
module tb_rx_pkt_parser;

    logic        Cclk = 1'b0;
    logic        rstn;
    logic [7:0]  RxByte;
    logic        RxByteValid, RxPktStart, RxPktEnd, RxCrcOk;
    logic        FraimSync, LineSync, RxAddValid, RxValid;
    logic [15:0] RxAdd;
    logic [11:0] RxData;
    logic [7:0]  ErrCnt;

    localparam int EV_FRM = 0, EV_ADDR = 1, EV_PIX = 2, EV_LINE = 3;

    typedef logic [7:0] byte_q_t [$];
    typedef struct { int kind; logic [15:0] val; } ev_t;

    ev_t exp_q [$];
    int  n_vec = 0;
    int  n_fail = 0;
    int  model_err = 0;

    rx_pkt_parser dut (
        .Cclk(Cclk), .rstn(rstn), .RxByte(RxByte), .RxByteValid(RxByteValid),
        .RxPktStart(RxPktStart), .RxPktEnd(RxPktEnd), .RxCrcOk(RxCrcOk),
        .FraimSync(FraimSync), .LineSync(LineSync), .RxAdd(RxAdd),
        .RxAddValid(RxAddValid), .RxData(RxData), .RxValid(RxValid), .ErrCnt(ErrCnt)
    );

    always #5 Cclk = ~Cclk;

    function automatic void chk(string name, int act, int req);
        n_vec++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endfunction

    function automatic void push_ev(int k, int v);
        ev_t e;
        e.kind = k;
        e.val  = 16'(v);
        exp_q.push_back(e);
    endfunction

    function automatic void mon_ev(int k, int v, string name);
        ev_t e;
        if (exp_q.size() == 0) begin
            chk({name, " unexpected pulse"}, 1, 0);
            return;
        end
        e = exp_q.pop_front();
        chk({name, " kind"}, k, e.kind);
        chk({name, " value"}, v, int'(e.val));
    endfunction

    // Monitor: every output pulse must match the head of the expectation queue.
    always @(negedge Cclk) begin
        if (rstn) begin
            if (RxAddValid && RxValid) chk("addr/pixel overlap", 1, 0);
            if (FraimSync)  mon_ev(EV_FRM, 0, "FraimSync");
            if (RxAddValid) mon_ev(EV_ADDR, int'(RxAdd), "RxAdd");
            if (RxValid)    mon_ev(EV_PIX, int'(RxData), "RxData");
            if (LineSync)   mon_ev(EV_LINE, 0, "LineSync");
        end
    end

    // Reference model: whole-packet view of what the parser must emit.
    function automatic void model_pkt(input byte_q_t b, input bit has_end);
        int inc = 0;
        int n, emitted, p, idx;
        int addr;
        if (b[0] == 8'hA5) begin
            if (has_end) push_ev(EV_FRM, 0);
        end else if (b[0] == 8'h5A) begin
            if (b.size() < 4) begin
                if (has_end) inc++;
            end else begin
                addr = {b[1], b[2]};
                n    = int'(b[3]);
                if (n == 0 || n > 64 || addr >= 'h9600) begin
                    inc++;
                end else begin
                    push_ev(EV_ADDR, addr);
                    emitted = 0;
                    for (int k = 0; k < n; k++) begin
                        p   = 4 + 3 * (k / 2);
                        idx = (k % 2 == 1) ? p + 2 : p + 1;
                        if (idx >= b.size()) break;
                        if (k % 2 == 0) push_ev(EV_PIX, {b[p], b[p+1][7:4]});
                        else            push_ev(EV_PIX, {b[p+1][3:0], b[p+2]});
                        emitted++;
                    end
                    if (has_end) begin
                        if (emitted == n) push_ev(EV_LINE, 0);
                        else              inc++;
                    end
                end
            end
        end
        if (!has_end) inc++;
        model_err += inc;
        if (model_err > 255) model_err = 255;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge Cclk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] v, input bit s, input bit e);
        RxByte      = v;
        RxByteValid = 1'b1;
        RxPktStart  = s;
        RxPktEnd    = e;
        @(posedge Cclk);
        #1;
        RxByteValid = 1'b0;
        RxPktStart  = 1'b0;
        RxPktEnd    = 1'b0;
    endtask

    task automatic run_pkt(input byte_q_t b, input bit has_end, input bit gaps);
        model_pkt(b, has_end);
        foreach (b[i]) begin
            send_byte(b[i], i == 0, has_end && (i == b.size() - 1));
            if (gaps && $urandom_range(0, 3) == 0) idle(1);
        end
        if (has_end) begin
            idle(2);
            chk("pending events", exp_q.size(), 0);
            chk("ErrCnt", int'(ErrCnt), model_err);
        end
    endtask

    initial begin
        byte_q_t     b;
        int          k, n, plen;
        logic [15:0] addr;
        logic [7:0]  t;
        bit          he;

        rstn = 1'b0;
        RxByte = '0;
        RxByteValid = 1'b0;
        RxPktStart = 1'b0;
        RxPktEnd = 1'b0;
        RxCrcOk = 1'b1;
        idle(2);
        chk("reset outputs", int'({FraimSync, LineSync, RxAddValid, RxValid, RxAdd, RxData}), 0);
        chk("reset ErrCnt", int'(ErrCnt), 0);
        rstn = 1'b1;
        idle(1);

        b = '{8'hA5};                                       run_pkt(b, 1, 0);
        b = '{8'h5A, 8'h00, 8'h50, 8'h02, 8'hAB, 8'hCD, 8'hEF}; run_pkt(b, 1, 0);
        b = '{8'h5A, 8'h00, 8'h00, 8'h01, 8'h12, 8'h3F};       run_pkt(b, 1, 0);
        b = '{8'h5A, 8'h96, 8'h00, 8'h01, 8'h12, 8'h34};       run_pkt(b, 1, 0);
        b = '{8'h5A, 8'h00, 8'h00, 8'h00};                     run_pkt(b, 1, 0);
        b = '{8'h5A, 8'h00, 8'h00, 8'h41, 8'h12, 8'h34};       run_pkt(b, 1, 0);
        b = '{8'h5A, 8'h00, 8'h10, 8'h04, 8'h11, 8'h22};       run_pkt(b, 1, 0);
        b = '{8'h5A, 8'h00, 8'h20, 8'h02, 8'h33};              run_pkt(b, 0, 0);
        b = '{8'h5A, 8'h00, 8'h30, 8'h02, 8'h44, 8'h55, 8'h66}; run_pkt(b, 1, 0);
        b = '{8'h5A};                                       run_pkt(b, 1, 0);
        b = '{8'h33, 8'h01, 8'h02};                         run_pkt(b, 1, 0);
        b = '{8'h5A, 8'h95, 8'hFF, 8'h40};                     run_pkt(b, 1, 0);

        for (int r = 0; r < 120; r++) begin
            b.delete();
            k = int'($urandom_range(0, 9));
            if (k == 0) begin
                b.push_back(8'hA5);
                repeat ($urandom_range(0, 2)) b.push_back(8'($urandom));
            end else if (k == 1) begin
                t = 8'($urandom);
                if (t == 8'hA5 || t == 8'h5A) t = 8'h00;
                b.push_back(t);
                repeat ($urandom_range(0, 3)) b.push_back(8'($urandom));
            end else begin
                k = int'($urandom_range(0, 9));
                if (k == 0)      n = 0;
                else if (k == 1) n = int'($urandom_range(65, 255));
                else             n = int'($urandom_range(1, 64));
                addr = ($urandom_range(0, 9) == 0) ? 16'($urandom_range('h9600, 'hFFFF))
                                                   : 16'($urandom_range(0, 'h95FF));
                b.push_back(8'h5A);
                b.push_back(addr[15:8]);
                b.push_back(addr[7:0]);
                b.push_back(8'(n));
                plen = (3 * n + 1) / 2;
                if (n > 64)                         plen = int'($urandom_range(0, 5));
                else if ($urandom_range(0, 4) == 0) plen = int'($urandom_range(0, plen));
                else                                plen += int'($urandom_range(0, 2));
                repeat (plen) b.push_back(8'($urandom));
            end
            he = ($urandom_range(0, 7) != 0);
            run_pkt(b, he, 1);
            if (he && $urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 2)) send_byte(8'($urandom), 1'b0, 1'($urandom));
        end

        // Drive the error counter into saturation.
        b = '{8'h5A};
        for (int i = 0; i < 260; i++) run_pkt(b, 1, 0);
        chk("ErrCnt saturated", int'(ErrCnt), 255);

        // Reset in the middle of a data header: everything clears, nothing follows.
        send_byte(8'h5A, 1'b1, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        rstn = 1'b0;
        #1;
        chk("midpkt reset outputs", int'({FraimSync, LineSync, RxAddValid, RxValid, RxAdd, RxData}), 0);
        chk("midpkt reset ErrCnt", int'(ErrCnt), 0);
        model_err = 0;
        idle(2);
        rstn = 1'b1;
        idle(3);
        b = '{8'hA5};
        run_pkt(b, 1, 0);
        b = '{8'h5A, 8'h01, 8'h00, 8'h02, 8'h9A, 8'hBC, 8'hDE};
        run_pkt(b, 1, 1);

        idle(3);
        chk("final pending events", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
